// File: rtl/cache_pkg.sv
// Shared cache/memory types: arbiter state encoding, abort read data, memory request struct.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port named by ptr.
// Latency: combinational; backpressure: none, the caller decides when to act on the pick.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    assign gnt_vld = |req;
    assign gnt_idx = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache (0) and dcache (1): round-robin, lockable bursts, watchdog.
// Latency: registered, >=3 cycles per beat; backpressure: requester holds valid until its rq_ready pulse.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned MAX_LOCK = 16,
    parameter int unsigned RR_INIT  = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  rq_valid,
    input  logic [1:0]  rq_lock,
    input  logic [1:0]  rq_instr,
    input  logic [31:0] rq_addr0,
    input  logic [31:0] rq_addr1,
    input  logic [31:0] rq_wdata0,
    input  logic [31:0] rq_wdata1,
    input  logic [3:0]  rq_wstrb0,
    input  logic [3:0]  rq_wstrb1,
    output logic [1:0]  rq_ready,
    output logic [31:0] rq_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        owner,
    output logic        err_timeout,
    output logic [31:0] gnt_cnt0,
    output logic [31:0] gnt_cnt1
);

    arb_state_t  state, state_nxt;
    mem_req_t    req_q, req_sel;
    logic        rr_ptr, locked, lock_pend;
    logic [31:0] tcnt, lock_cnt;
    logic [1:0]  arb_req;
    logic        pick_vld, pick_idx;
    logic        busy, mem_done, wd_fire, unlock_idle;

    // While locked only the owner may be picked; the other port is masked out.
    always_comb begin
        arb_req = rq_valid;
        if (locked) begin
            arb_req = owner ? {rq_valid[1], 1'b0} : {1'b0, rq_valid[0]};
        end
    end

    rr_arbiter2 u_rr (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt_vld (pick_vld),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        req_sel       = '0;
        req_sel.valid = 1'b1;
        if (pick_idx) begin
            req_sel.instr = rq_instr[1];
            req_sel.addr  = rq_addr1;
            req_sel.wdata = rq_wdata1;
            req_sel.wstrb = rq_wstrb1;
        end else begin
            req_sel.instr = rq_instr[0];
            req_sel.addr  = rq_addr0;
            req_sel.wdata = rq_wdata0;
            req_sel.wstrb = rq_wstrb0;
        end
    end

    assign busy        = (state == ST_ISSUE) || (state == ST_WAIT);
    assign mem_done    = busy && mem_ready;
    assign wd_fire     = busy && !mem_ready && (TIMEOUT != 0) && (tcnt == TIMEOUT);
    assign unlock_idle = locked && !rq_valid[owner] && !rq_lock[owner];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:            if (pick_vld) state_nxt = ST_ISSUE;
            ST_ISSUE, ST_WAIT:  state_nxt = (mem_done || wd_fire) ? ST_RELEASE : ST_WAIT;
            ST_RELEASE:         state_nxt = ST_IDLE;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q       <= '0;
            owner       <= 1'b0;
            rr_ptr      <= (RR_INIT != 0);
            locked      <= 1'b0;
            lock_pend   <= 1'b0;
            lock_cnt    <= '0;
            tcnt        <= '0;
            rq_ready    <= 2'b00;
            rq_rdata    <= '0;
            err_timeout <= 1'b0;
            gnt_cnt0    <= '0;
            gnt_cnt1    <= '0;
        end else begin
            rq_ready <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (unlock_idle) begin
                        locked   <= 1'b0;
                        lock_cnt <= '0;
                        rr_ptr   <= ~owner;
                    end else if (pick_vld) begin
                        owner <= pick_idx;
                        req_q <= req_sel;
                        tcnt  <= '0;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (mem_done) begin
                        req_q.valid     <= 1'b0;
                        rq_rdata        <= mem_rdata;
                        rq_ready[owner] <= 1'b1;
                        lock_pend       <= rq_lock[owner];
                        if (owner) gnt_cnt1 <= gnt_cnt1 + 32'd1;
                        else       gnt_cnt0 <= gnt_cnt0 + 32'd1;
                    end else if (wd_fire) begin
                        // Aborted beats never hold the lock: a stuck target must not starve the other port.
                        req_q.valid     <= 1'b0;
                        rq_rdata        <= ABORT_RDATA;
                        rq_ready[owner] <= 1'b1;
                        err_timeout     <= 1'b1;
                        lock_pend       <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                ST_RELEASE: begin
                    if (lock_pend && (lock_cnt < MAX_LOCK - 32'd1)) begin
                        lock_cnt <= lock_cnt + 32'd1;
                        locked   <= 1'b1;
                    end else begin
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                        rr_ptr   <= ~owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_valid = req_q.valid;
    assign mem_instr = req_q.instr;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: requester/memory drivers, completion monitor, directed tests.
module tb_cache_mem_arbiter;

    localparam int unsigned TO = 8;
    localparam int unsigned ML = 4;

    typedef struct packed { logic [31:0] addr; logic lock; } beat_t;
    typedef struct packed { logic port; logic [31:0] addr; logic [31:0] rdata; } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0;
    logic [1:0]  rq_valid, rq_lock, rq_instr;
    logic [31:0] rq_wdata0, rq_wdata1;
    logic [3:0]  rq_wstrb0, rq_wstrb1;
    logic [1:0]  rq_ready;
    logic [31:0] rq_rdata, mem_addr, mem_wdata, gnt_cnt0, gnt_cnt1;
    logic        mem_valid, mem_instr, owner, err_timeout;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    assign rq_valid  = {v1, v0};
    assign rq_lock   = {l1, l0};
    assign rq_instr  = 2'b01;
    assign rq_wdata0 = ~a0;
    assign rq_wdata1 = ~a1;
    assign rq_wstrb0 = 4'h0;
    assign rq_wstrb1 = 4'hF;

    int checks = 0;
    int failures = 0;
    beat_t pq0[$];
    beat_t pq1[$];
    exp_t  sb[$];
    int    mem_lat = 0;
    logic  mem_stall = 1'b0;
    logic [31:0] obs_addr = '0, obs_wdata = '0, hold_addr = '0;
    logic        obs_instr = 1'b0;
    logic [3:0]  obs_wstrb = '0;
    int    t4_ord [13] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0};

    cache_mem_arbiter #(.TIMEOUT(TO), .MAX_LOCK(ML), .RR_INIT(0)) dut (
        .clk(clk), .resetn(resetn),
        .rq_valid(rq_valid), .rq_lock(rq_lock), .rq_instr(rq_instr),
        .rq_addr0(a0), .rq_addr1(a1), .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
        .rq_wstrb0(rq_wstrb0), .rq_wstrb1(rq_wstrb1),
        .rq_ready(rq_ready), .rq_rdata(rq_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .owner(owner), .err_timeout(err_timeout),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a + 32'h0000_1134;
    endfunction

    task automatic push_exp(input logic p, input logic [31:0] addr, input logic [31:0] rd);
        exp_t e;
        e.port = p; e.addr = addr; e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic push_beat(input logic p, input logic [31:0] addr, input logic lock);
        beat_t b;
        b.addr = addr; b.lock = lock;
        if (p) pq1.push_back(b);
        else   pq0.push_back(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || pq0.size() != 0 || pq1.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(sb.size() + pq0.size() + pq1.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Requesters: present queued beats, hold until rq_ready, then move to the next one.
    initial begin
        logic b0, b1;
        b0 = 1'b0; b1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                b0 = 1'b0; b1 = 1'b0; v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
            end else begin
                if (b0 && rq_ready[0]) begin pq0.delete(0); b0 = 1'b0; end
                if (!b0 && pq0.size() != 0) begin
                    v0 = 1'b1; a0 = pq0[0].addr; l0 = pq0[0].lock; b0 = 1'b1;
                end else if (!b0) begin
                    v0 = 1'b0; l0 = 1'b0;
                end
                if (b1 && rq_ready[1]) begin pq1.delete(0); b1 = 1'b0; end
                if (!b1 && pq1.size() != 0) begin
                    v1 = 1'b1; a1 = pq1[0].addr; l1 = pq1[0].lock; b1 = 1'b1;
                end else if (!b1) begin
                    v1 = 1'b0; l1 = 1'b0;
                end
            end
        end
    end

    // Memory: answers mem_valid after mem_lat cycles (never while stalled), checks request stability.
    initial begin
        logic in_beat;
        int   wcnt;
        in_beat = 1'b0; wcnt = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_valid) begin
                if (!in_beat) begin
                    in_beat = 1'b1; hold_addr = mem_addr; wcnt = 0;
                end else begin
                    chk("mem_addr_stable", mem_addr, hold_addr);
                end
                obs_addr = mem_addr; obs_instr = mem_instr; obs_wstrb = mem_wstrb; obs_wdata = mem_wdata;
                if (!mem_stall) begin
                    if (wcnt == mem_lat) begin
                        mem_ready = 1'b1;
                        mem_rdata = mem_model(mem_addr);
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                in_beat = 1'b0;
            end
        end
    end

    // Completion monitor: every rq_ready pulse is matched against the next scoreboard entry.
    initial begin
        exp_t e;
        logic p;
        forever begin
            @(negedge clk);
            if (rq_ready != 2'b00) begin
                chk("rq_ready_onehot", 32'(rq_ready == 2'b11), 32'd0);
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    p = rq_ready[1];
                    chk("grant_port", 32'(p), 32'(e.port));
                    chk("owner", 32'(owner), 32'(e.port));
                    chk("rq_rdata", rq_rdata, e.rdata);
                    chk("mem_addr", obs_addr, e.addr);
                    chk("mem_instr", 32'(obs_instr), 32'(!e.port));
                    chk("mem_wstrb", 32'(obs_wstrb), e.port ? 32'hF : 32'h0);
                    chk("mem_wdata", obs_wdata, ~e.addr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n0, n1, n, vcnt;

        // Reset state
        do_reset();
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_rq_ready", 32'(rq_ready), 32'd0);
        chk("rst_rq_rdata", rq_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_gnt0", gnt_cnt0, 32'd0);
        chk("rst_gnt1", gnt_cnt1, 32'd0);

        // Single icache read, memory answers after 3 cycles
        mem_lat = 3;
        push_exp(1'b0, 32'h100, 32'h1234);
        push_beat(1'b0, 32'h100, 1'b0);
        wait_drain("t1_drain");
        chk("t1_gnt0", gnt_cnt0, 32'd1);
        chk("t1_gnt1", gnt_cnt1, 32'd0);
        chk("t1_rdata_hold", rq_rdata, 32'h1234);

        // Both ports continuously requesting: strict alternation from port 0
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 32'h1000 + 32'(4 * i), mem_model(32'h1000 + 32'(4 * i)));
            push_exp(1'b1, 32'h2000 + 32'(4 * i), mem_model(32'h2000 + 32'(4 * i)));
        end
        for (int i = 0; i < 4; i++) begin
            push_beat(1'b0, 32'h1000 + 32'(4 * i), 1'b0);
            push_beat(1'b1, 32'h2000 + 32'(4 * i), 1'b0);
        end
        wait_drain("t2_drain");
        chk("t2_gnt0", gnt_cnt0, 32'd4);
        chk("t2_gnt1", gnt_cnt1, 32'd4);

        // Locked 2-word fill on port 1 keeps port 0 out until the fill ends
        do_reset();
        mem_lat = 1;
        push_exp(1'b1, 32'h200, 32'h1334);
        push_exp(1'b1, 32'h204, 32'h1338);
        push_exp(1'b0, 32'h0A0, 32'h11D4);
        push_beat(1'b1, 32'h200, 1'b1);
        push_beat(1'b1, 32'h204, 1'b0);
        repeat (2) @(negedge clk);
        push_beat(1'b0, 32'h0A0, 1'b0);
        wait_drain("t3_drain");
        chk("t3_gnt1", gnt_cnt1, 32'd2);
        chk("t3_gnt0", gnt_cnt0, 32'd1);

        // Port 1 locked for 10 beats: forced rotation after every 4th locked beat
        do_reset();
        mem_lat = 0;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 13; i++) begin
            if (t4_ord[i] == 1) begin
                push_exp(1'b1, 32'h400 + 32'(4 * n1), mem_model(32'h400 + 32'(4 * n1)));
                n1++;
            end else begin
                push_exp(1'b0, 32'h500 + 32'(4 * n0), mem_model(32'h500 + 32'(4 * n0)));
                n0++;
            end
        end
        for (int i = 0; i < 10; i++) push_beat(1'b1, 32'h400 + 32'(4 * i), 1'b1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) push_beat(1'b0, 32'h500 + 32'(4 * i), 1'b0);
        wait_drain("t4_drain");
        chk("t4_gnt1", gnt_cnt1, 32'd10);
        chk("t4_gnt0", gnt_cnt0, 32'd3);

        // Watchdog: memory never answers
        do_reset();
        mem_stall = 1'b1;
        push_exp(1'b0, 32'h300, 32'hDEAD_BEEF);
        push_beat(1'b0, 32'h300, 1'b0);
        vcnt = 0; n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (rq_ready != 2'b00) break;
            if (mem_valid) vcnt++;
        end
        chk("t5_ready_seen", 32'(rq_ready[0]), 32'd1);
        chk("t5_valid_cycles", 32'(vcnt), TO + 1);
        wait_drain("t5_drain");
        chk("t5_err", 32'(err_timeout), 32'd1);
        chk("t5_gnt0", gnt_cnt0, 32'd0);
        mem_stall = 1'b0;
        push_exp(1'b1, 32'h310, 32'h1444);
        push_beat(1'b1, 32'h310, 1'b0);
        wait_drain("t5b_drain");
        chk("t5_err_sticky", 32'(err_timeout), 32'd1);
        chk("t5_gnt1", gnt_cnt1, 32'd1);

        // Asynchronous reset in the middle of a waiting beat
        do_reset();
        mem_stall = 1'b1;
        push_beat(1'b1, 32'h600, 1'b0);
        n = 0;
        while (!mem_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_valid_seen", 32'(mem_valid), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_mem_valid", 32'(mem_valid), 32'd0);
        chk("t6_mem_addr", mem_addr, 32'd0);
        chk("t6_owner", 32'(owner), 32'd0);
        chk("t6_rq_ready", 32'(rq_ready), 32'd0);
        pq1.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_ready", 32'(rq_ready), 32'd0);
        end
        resetn = 1'b1;
        mem_stall = 1'b0;
        mem_lat = 2;
        push_exp(1'b0, 32'h604, 32'h1738);
        push_beat(1'b0, 32'h604, 1'b0);
        wait_drain("t6_drain");
        chk("t6_gnt0", gnt_cnt0, 32'd1);
        chk("t6_gnt1", gnt_cnt1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
